// File: rtl/mem_access.sv
// mem_access: memory-access stage with a single-outstanding req/ack data port and writeback beat.
// Optional misaligned-access faulting is compiled in when MEM_MISALIGN_CHECK_EN is defined.
`ifndef BUS_L_CODE
`define BUS_L_CODE 3
`endif
`ifndef BUS_S_CODE
`define BUS_S_CODE 2
`endif
`ifndef INSTR_LB
`define INSTR_LB  3'd1
`define INSTR_LH  3'd2
`define INSTR_LW  3'd3
`define INSTR_LBU 3'd4
`define INSTR_LHU 3'd5
`endif
`ifndef INSTR_SB
`define INSTR_SB 2'd1
`define INSTR_SH 2'd2
`define INSTR_SW 2'd3
`endif
`ifndef MEM_WR_EN
`define MEM_WR_EN 1'b1
`endif

module mem_access #(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [31:0]            alu_result,
    input  logic [31:0]            addr_mem_rd,
    input  logic [31:0]            addr_mem_wr,
    input  logic [31:0]            data_mem_wr,
    input  logic                   mem_state,
    input  logic [`BUS_L_CODE-1:0] load_code,
    input  logic [`BUS_S_CODE-1:0] store_code,
    input  logic [4:0]             rd_addr,
    input  logic                   rd_wen,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [31:0]            dmem_addr,
    output logic [31:0]            dmem_wdata,
    output logic [3:0]             dmem_be,
    input  logic                   dmem_ack,
    input  logic [31:0]            dmem_rdata,
    output logic                   wb_valid,
    output logic [4:0]             wb_rd,
    output logic                   wb_wen,
    output logic [31:0]            wb_data,
    output logic                   bus_fault,
    output logic [31:0]            fault_addr
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(ACK_TIMEOUT);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    function automatic logic is_load(input logic [`BUS_L_CODE-1:0] code);
        return (code == `INSTR_LB) || (code == `INSTR_LH) || (code == `INSTR_LW) ||
               (code == `INSTR_LBU) || (code == `INSTR_LHU);
    endfunction

    function automatic logic [31:0] load_extract(input logic [`BUS_L_CODE-1:0] code,
                                                 input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (code)
            `INSTR_LB:  return {{24{b[7]}}, b};
            `INSTR_LBU: return {24'b0, b};
            `INSTR_LH:  return {{16{h[15]}}, h};
            `INSTR_LHU: return {16'b0, h};
            default:    return word;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [`BUS_S_CODE-1:0] code,
                                            input logic [1:0] lane);
        case (code)
            `INSTR_SB: return 4'b0001 << lane;
            `INSTR_SH: return 4'b0011 << {lane[1], 1'b0};
            `INSTR_SW: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [`BUS_S_CODE-1:0] code,
                                               input logic [1:0] lane,
                                               input logic [31:0] data);
        case (code)
            `INSTR_SB: return {24'b0, data[7:0]} << {lane, 3'b000};
            `INSTR_SH: return {16'b0, data[15:0]} << {lane[1], 4'b0000};
            default:   return data;
        endcase
    endfunction

`ifdef MEM_MISALIGN_CHECK_EN
    function automatic logic misaligned(input logic ld,
                                        input logic [`BUS_L_CODE-1:0] lcode,
                                        input logic [`BUS_S_CODE-1:0] scode,
                                        input logic [1:0] lane);
        if (ld) begin
            if (lcode == `INSTR_LH || lcode == `INSTR_LHU) return lane[0];
            if (lcode == `INSTR_LW)                        return lane != 2'b00;
            return 1'b0;
        end
        if (scode == `INSTR_SH) return lane[0];
        if (scode == `INSTR_SW) return lane != 2'b00;
        return 1'b0;
    endfunction
`endif

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_is_load;
    logic [`BUS_L_CODE-1:0]   r_lcode;
    logic [31:0]              r_addr;
    logic [4:0]               r_rd;
    logic                     r_wen;
    logic                     r_dmem_req;
    logic                     r_dmem_we;
    logic [31:0]              r_dmem_addr;
    logic [31:0]              r_dmem_wdata;
    logic [3:0]               r_dmem_be;
    logic                     r_wb_valid;
    logic [4:0]               r_wb_rd;
    logic                     r_wb_wen;
    logic [31:0]              r_wb_data;
    logic                     r_bus_fault;
    logic [31:0]              r_fault_addr;

    logic        w_is_load;
    logic        w_is_store;
    logic [31:0] w_addr;

    // A valid load encoding wins over a simultaneous store marking.
    assign w_is_load  = is_load(load_code);
    assign w_is_store = !w_is_load && (mem_state == `MEM_WR_EN);
    assign w_addr     = w_is_load ? addr_mem_rd : addr_mem_wr;

    assign ex_ready   = (r_state == S_IDLE) && !rst;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign dmem_be    = r_dmem_be;
    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_wb_rd;
    assign wb_wen     = r_wb_wen;
    assign wb_data    = r_wb_data;
    assign bus_fault  = r_bus_fault;
    assign fault_addr = r_fault_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_is_load    <= 1'b0;
            r_lcode      <= '0;
            r_addr       <= '0;
            r_rd         <= '0;
            r_wen        <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_be    <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_wen     <= 1'b0;
            r_wb_data    <= '0;
            r_bus_fault  <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_bus_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (!(w_is_load || w_is_store)) begin
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= alu_result;
                            r_wb_rd    <= rd_addr;
                            r_wb_wen   <= rd_wen;
`ifdef MEM_MISALIGN_CHECK_EN
                        end else if (misaligned(w_is_load, load_code, store_code, w_addr[1:0])) begin
                            r_wb_valid   <= 1'b1;
                            r_wb_rd      <= rd_addr;
                            r_wb_wen     <= 1'b0;
                            r_bus_fault  <= 1'b1;
                            r_fault_addr <= w_addr;
`endif
                        end else begin
                            r_state      <= S_ACCESS;
                            r_cnt        <= '0;
                            r_is_load    <= w_is_load;
                            r_lcode      <= load_code;
                            r_addr       <= w_addr;
                            r_rd         <= rd_addr;
                            r_wen        <= rd_wen;
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= !w_is_load;
                            r_dmem_addr  <= {w_addr[31:2], 2'b00};
                            r_dmem_be    <= w_is_load ? 4'b0000 : store_be(store_code, w_addr[1:0]);
                            r_dmem_wdata <= w_is_load ? 32'b0 : store_data(store_code, w_addr[1:0], data_mem_wr);
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack in the timeout cycle still completes the access normally.
                    if (dmem_ack) begin
                        r_state    <= S_IDLE;
                        r_dmem_req <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        if (r_is_load) begin
                            r_wb_wen  <= r_wen;
                            r_wb_data <= load_extract(r_lcode, r_addr[1:0], dmem_rdata);
                        end else begin
                            r_wb_wen  <= 1'b0;
                        end
                    end else if (r_cnt == TMO) begin
                        r_state      <= S_IDLE;
                        r_dmem_req   <= 1'b0;
                        r_wb_valid   <= 1'b1;
                        r_wb_rd      <= r_rd;
                        r_wb_wen     <= 1'b0;
                        r_bus_fault  <= 1'b1;
                        r_fault_addr <= r_addr;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected writeback beats are queued at issue and
// compared by a monitor when wb_valid fires; tasks check bus-side behaviour inline.
module tb_mem_access;
    localparam int ACK_T = 4;
    localparam logic [2:0] LC_NONE = 3'd0, LC_LB = 3'd1, LC_LH = 3'd2, LC_LW = 3'd3,
                           LC_LBU = 3'd4, LC_LHU = 3'd5;
    localparam logic [1:0] SC_NONE = 2'd0, SC_SB = 2'd1, SC_SH = 2'd2, SC_SW = 2'd3;

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] data;
        logic        fault;
        logic        chk;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_result, addr_mem_rd, addr_mem_wr, data_mem_wr;
    logic        mem_state;
    logic [2:0]  load_code;
    logic [1:0]  store_code;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [31:0] wb_data;
    logic        bus_fault;
    logic [31:0] fault_addr;

    int    vecs  = 0;
    int    fails = 0;
    beat_t sb[$];
    beat_t mon_e;

    mem_access #(.ACK_TIMEOUT(ACK_T)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_result(alu_result), .addr_mem_rd(addr_mem_rd), .addr_mem_wr(addr_mem_wr),
        .data_mem_wr(data_mem_wr), .mem_state(mem_state), .load_code(load_code),
        .store_code(store_code), .rd_addr(rd_addr), .rd_wen(rd_wen),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .wb_data(wb_data), .bus_fault(bus_fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    // Writeback monitor: every beat must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            vecs++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected act rd=%0d wen=%b data=%h fault=%b req=none",
                         wb_rd, wb_wen, wb_data, bus_fault);
            end else begin
                mon_e = sb.pop_front();
                if (wb_rd !== mon_e.rd || wb_wen !== mon_e.wen || bus_fault !== mon_e.fault ||
                    (mon_e.chk && wb_data !== mon_e.data)) begin
                    fails++;
                    $display("FAIL wb_beat act rd=%0d wen=%b data=%h fault=%b req rd=%0d wen=%b data=%h fault=%b",
                             wb_rd, wb_wen, wb_data, bus_fault, mon_e.rd, mon_e.wen, mon_e.data, mon_e.fault);
                end
            end
        end
    end

    task automatic idle_inputs();
        ex_valid    = 1'b0;
        load_code   = LC_NONE;
        store_code  = SC_NONE;
        mem_state   = 1'b0;
        addr_mem_rd = 32'hDEAD_BEEF;
        addr_mem_wr = 32'hDEAD_BEEF;
        data_mem_wr = 32'hDEAD_BEEF;
        alu_result  = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        rd_addr = 5'd0; rd_wen = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        vecs++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_be !== 4'h0 || wb_valid !== 1'b0 ||
            wb_wen !== 1'b0 || bus_fault !== 1'b0 || ex_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl act req=%b we=%b be=%h wbv=%b wen=%b flt=%b rdy=%b req all 0",
                     dmem_req, dmem_we, dmem_be, wb_valid, wb_wen, bus_fault, ex_ready);
        end
        vecs++;
        if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || wb_data !== 32'h0 ||
            wb_rd !== 5'd0 || fault_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_data act addr=%h wdata=%h wbd=%h rd=%0d fa=%h req all 0",
                     dmem_addr, dmem_wdata, wb_data, wb_rd, fault_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (ex_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset act=%b req=1", ex_ready);
        end
    endtask

    task automatic test_back_to_back();
        beat_t b;
        @(negedge clk);
        ex_valid = 1'b1; alu_result = 32'h11; rd_addr = 5'd1; rd_wen = 1'b1;
        b = '{5'd1, 1'b1, 32'h11, 1'b0, 1'b1}; sb.push_back(b);
        @(negedge clk);
        vecs++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h11 || ex_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first act v=%b d=%h rdy=%b req v=1 d=11 rdy=1", wb_valid, wb_data, ex_ready);
        end
        alu_result = 32'h22; rd_addr = 5'd2;
        b = '{5'd2, 1'b1, 32'h22, 1'b0, 1'b1}; sb.push_back(b);
        @(negedge clk);
        ex_valid = 1'b0;
        vecs++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h22 || ex_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second act v=%b d=%h rdy=%b req v=1 d=22 rdy=1", wb_valid, wb_data, ex_ready);
        end
        @(negedge clk);
        vecs++;
        if (wb_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_pulse act v=%b req 0", wb_valid);
        end
    endtask

    // Issue one memory op, ack it after 'waits' extra ACCESS cycles, check bus-side holds.
    task automatic run_access(input string nm, input logic [2:0] lc, input logic [1:0] sc,
                              input logic st, input logic [31:0] addr, input logic [31:0] wd,
                              input int waits, input logic [31:0] rdata,
                              input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_be,
                              input logic [31:0] e_wd, input logic [31:0] e_data);
        beat_t b;
        logic  ld;
        ld = (lc != LC_NONE);
        @(negedge clk);
        ex_valid = 1'b1; load_code = lc; store_code = sc; mem_state = st;
        addr_mem_rd = addr; addr_mem_wr = addr; data_mem_wr = wd;
        rd_addr = 5'd7; rd_wen = 1'b1;
        b = '{5'd7, ld, e_data, 1'b0, ld}; sb.push_back(b);
        vecs++;
        if (ex_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_ready_idle act=%b req=1", nm, ex_ready);
        end
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i <= waits; i++) begin
            vecs++;
            if (dmem_req !== 1'b1 || dmem_addr !== e_addr || dmem_we !== e_we || dmem_be !== e_be ||
                dmem_wdata !== e_wd || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
                fails++;
                $display("FAIL %s_access[%0d] act req=%b a=%h we=%b be=%b wd=%h rdy=%b wbv=%b req req=1 a=%h we=%b be=%b wd=%h rdy=0 wbv=0",
                         nm, i, dmem_req, dmem_addr, dmem_we, dmem_be, dmem_wdata, ex_ready, wb_valid,
                         e_addr, e_we, e_be, e_wd);
            end
            if (i == waits) begin
                dmem_ack = 1'b1; dmem_rdata = rdata;
            end
            @(negedge clk);
        end
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        vecs++;
        if (dmem_req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s_complete act req=%b rdy=%b wbv=%b req req=0 rdy=1 wbv=1",
                     nm, dmem_req, ex_ready, wb_valid);
        end
    endtask

    task automatic test_loads();
        run_access("lb",  LC_LB,  SC_NONE, 1'b0, 32'h1003, 32'h0, 3, 32'h80FF_FFFF,
                   32'h1000, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80);
        run_access("lbu", LC_LBU, SC_NONE, 1'b0, 32'h1003, 32'h0, 3, 32'h80FF_FFFF,
                   32'h1000, 1'b0, 4'b0000, 32'h0, 32'h0000_0080);
        run_access("lh",  LC_LH,  SC_NONE, 1'b0, 32'h1002, 32'h0, 0, 32'h8001_0000,
                   32'h1000, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8001);
        run_access("lhu", LC_LHU, SC_NONE, 1'b0, 32'h1002, 32'h0, 1, 32'h8001_0000,
                   32'h1000, 1'b0, 4'b0000, 32'h0, 32'h0000_8001);
        // Load encoding with the store marker also set must still read.
        run_access("ld_prio", LC_LW, SC_SW, 1'b1, 32'h1104, 32'h5555_5555, 0, 32'h0BAD_F00D,
                   32'h1104, 1'b0, 4'b0000, 32'h0, 32'h0BAD_F00D);
        // Ack landing in the timeout cycle completes normally.
        run_access("ack_at_tmo", LC_LW, SC_NONE, 1'b0, 32'h1200, 32'h0, ACK_T, 32'h1357_9BDF,
                   32'h1200, 1'b0, 4'b0000, 32'h0, 32'h1357_9BDF);
    endtask

    task automatic test_stores();
        run_access("sh", LC_NONE, SC_SH, 1'b1, 32'h2002, 32'h0000_BEEF, 2, 32'h0,
                   32'h2000, 1'b1, 4'b1100, 32'hBEEF_0000, 32'h0);
        run_access("sb", LC_NONE, SC_SB, 1'b1, 32'h2101, 32'h0000_00AB, 0, 32'h0,
                   32'h2100, 1'b1, 4'b0010, 32'h0000_AB00, 32'h0);
        run_access("sw", LC_NONE, SC_SW, 1'b1, 32'h2200, 32'hCAFE_BABE, 1, 32'h0,
                   32'h2200, 1'b1, 4'b1111, 32'hCAFE_BABE, 32'h0);
    endtask

    task automatic test_timeout();
        beat_t b;
        @(negedge clk);
        ex_valid = 1'b1; load_code = LC_LW; addr_mem_rd = 32'h4000; rd_addr = 5'd9; rd_wen = 1'b1;
        b = '{5'd9, 1'b0, 32'h0, 1'b1, 1'b0}; sb.push_back(b);
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i <= ACK_T; i++) begin
            vecs++;
            if (dmem_req !== 1'b1 || bus_fault !== 1'b0) begin
                fails++;
                $display("FAIL tmo_wait[%0d] act req=%b flt=%b req req=1 flt=0", i, dmem_req, bus_fault);
            end
            @(negedge clk);
        end
        vecs++;
        if (bus_fault !== 1'b1 || wb_valid !== 1'b1 || dmem_req !== 1'b0 ||
            fault_addr !== 32'h4000 || ex_ready !== 1'b1) begin
            fails++;
            $display("FAIL tmo_fault act flt=%b wbv=%b req=%b fa=%h rdy=%b req flt=1 wbv=1 req=0 fa=4000 rdy=1",
                     bus_fault, wb_valid, dmem_req, fault_addr, ex_ready);
        end
        ex_valid = 1'b1; alu_result = 32'h33; rd_addr = 5'd3;
        b = '{5'd3, 1'b1, 32'h33, 1'b0, 1'b1}; sb.push_back(b);
        @(negedge clk);
        ex_valid = 1'b0;
        vecs++;
        if (bus_fault !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'h33 || fault_addr !== 32'h4000) begin
            fails++;
            $display("FAIL tmo_after act flt=%b wbv=%b d=%h fa=%h req flt=0 wbv=1 d=33 fa=4000",
                     bus_fault, wb_valid, wb_data, fault_addr);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        ex_valid = 1'b1; load_code = LC_LW; addr_mem_rd = 32'h5000; rd_addr = 5'd4; rd_wen = 1'b1;
        @(negedge clk);
        idle_inputs();
        vecs++;
        if (dmem_req !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_req act=%b req=1", dmem_req);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vecs++;
        if (dmem_req !== 1'b0 || ex_ready !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_drop act req=%b rdy=%b req req=0 rdy=0", dmem_req, ex_ready);
        end
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        vecs++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_late_ack act wbv=%b req=%b rdy=%b req wbv=0 req=0 rdy=1",
                     wb_valid, dmem_req, ex_ready);
        end
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_CHECK_EN
        beat_t b;
        @(negedge clk);
        ex_valid = 1'b1; load_code = LC_LW; addr_mem_rd = 32'h3002; rd_addr = 5'd6; rd_wen = 1'b1;
        b = '{5'd6, 1'b0, 32'h0, 1'b1, 1'b0}; sb.push_back(b);
        @(negedge clk);
        idle_inputs();
        vecs++;
        if (dmem_req !== 1'b0 || bus_fault !== 1'b1 || fault_addr !== 32'h3002 || ex_ready !== 1'b1) begin
            fails++;
            $display("FAIL misalign_lw act req=%b flt=%b fa=%h rdy=%b req req=0 flt=1 fa=3002 rdy=1",
                     dmem_req, bus_fault, fault_addr, ex_ready);
        end
`else
        run_access("lw_unal", LC_LW, SC_NONE, 1'b0, 32'h3002, 32'h0, 1, 32'hCAFE_F00D,
                   32'h3000, 1'b0, 4'b0000, 32'h0, 32'hCAFE_F00D);
        run_access("lh_unal", LC_LH, SC_NONE, 1'b0, 32'h6001, 32'h0, 0, 32'h1234_8765,
                   32'h6000, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8765);
        run_access("sw_unal", LC_NONE, SC_SW, 1'b1, 32'h6102, 32'h0102_0304, 0, 32'h0,
                   32'h6100, 1'b1, 4'b1111, 32'h0102_0304, 32'h0);
`endif
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_loads();
        test_stores();
        test_timeout();
        test_reset_mid_access();
        test_misalign();
        repeat (3) @(negedge clk);
        vecs++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL wb_missing act pending=%0d req=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
